// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state encoding and op decode for the multi-cycle mul/div unit.
package mul_div_unit_pkg;

  localparam int MDU_OP_W = 4;

  typedef enum logic [3:0] {
    MDU_MUL    = 4'd0,
    MDU_MULH   = 4'd1,
    MDU_MULHSU = 4'd2,
    MDU_MULHU  = 4'd3,
    MDU_DIV    = 4'd4,
    MDU_DIVU   = 4'd5,
    MDU_REM    = 4'd6,
    MDU_REMU   = 4'd7,
    MDU_MULW   = 4'd8,
    MDU_DIVW   = 4'd9,
    MDU_DIVUW  = 4'd10,
    MDU_REMW   = 4'd11,
    MDU_REMUW  = 4'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic valid;
    logic mul;
    logic mul_hi;
    logic rem;
    logic word;
    logic zext;
    logic a_signed;
    logic b_signed;
  } mdu_dec_t;

  function automatic mdu_dec_t mdu_decode(input mdu_op_e op);
    mdu_dec_t d;
    d       = '0;
    d.valid = 1'b1;
    case (op)
      MDU_MUL:    begin d.mul = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MDU_MULH:   begin d.mul = 1'b1; d.mul_hi = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MDU_MULHSU: begin d.mul = 1'b1; d.mul_hi = 1'b1; d.a_signed = 1'b1; end
      MDU_MULHU:  begin d.mul = 1'b1; d.mul_hi = 1'b1; end
      MDU_DIV:    begin d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MDU_DIVU:   ;
      MDU_REM:    begin d.rem = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MDU_REMU:   d.rem = 1'b1;
      MDU_MULW:   begin d.mul = 1'b1; d.word = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MDU_DIVW:   begin d.word = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MDU_DIVUW:  begin d.word = 1'b1; d.zext = 1'b1; end
      MDU_REMW:   begin d.rem = 1'b1; d.word = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      MDU_REMUW:  begin d.rem = 1'b1; d.word = 1'b1; d.zext = 1'b1; end
      default:    d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on the {hi,lo} pair.
module mul_div_unit_iter_step #(
  parameter int XLEN = 64
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, opb_i};
    hi_o    = sum[XLEN:1];
    lo_o    = {sum[0], lo_i[XLEN-1:1]};
    if (is_div) begin
      // Partial remainder is always below 2*divisor, so diff's top bit is the borrow.
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = shifted[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV64M mul/div/rem unit: valid/ready on both sides, one result bit per BUSY cycle.
// state | meaning
// IDLE  | in_ready high, waiting for an op
// BUSY  | iterating, one bit per cycle for XLEN cycles
// DONE  | out_valid high, mdu_result held until out_ready
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OPW  = MDU_OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  mdu_op,
  input  logic [XLEN-1:0] operator_1,
  input  logic [XLEN-1:0] operator_2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_result
);

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mdu_op_e         op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic            quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;

  mdu_dec_t        in_dec, cur_dec;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val;
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, res_raw;

  function automatic logic [XLEN-1:0] narrow(input logic [XLEN-1:0] v, input logic zext);
    return zext ? {{HW{1'b0}}, v[HW-1:0]} : {{HW{v[HW-1]}}, v[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic word);
    return word ? narrow(v, 1'b0) : v;
  endfunction

  assign in_dec  = mdu_decode(mdu_op_e'(mdu_op));
  assign cur_dec = mdu_decode(op_q);

  mul_div_unit_iter_step #(.XLEN(XLEN)) u_step (
    .is_div (~cur_dec.mul),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opb_i  (opb_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Operand preparation for the op being offered this cycle.
  always_comb begin
    a_ext    = in_dec.word ? narrow(operator_1, in_dec.zext) : operator_1;
    b_ext    = in_dec.word ? narrow(operator_2, in_dec.zext) : operator_2;
    a_neg    = in_dec.a_signed & a_ext[XLEN-1];
    b_neg    = in_dec.b_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    min_val  = in_dec.word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = ~in_dec.mul & (b_ext == '0);
    div_ovf  = ~in_dec.mul & in_dec.b_signed & (a_ext == min_val) & (b_ext == '1);
  end

  // Sign fixup and result selection on the last iteration.
  always_comb begin
    prod_fix = quot_neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    quot_fix = quot_neg_q ? -step_lo : step_lo;
    rem_fix  = rem_neg_q ? -step_hi : step_hi;
    if (cur_dec.mul) begin
      res_raw = cur_dec.mul_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end else begin
      res_raw = cur_dec.rem ? rem_fix : quot_fix;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush && in_valid) begin
          op_d  = mdu_op_e'(mdu_op);
          cnt_d = '0;
          if (!in_dec.valid) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else if (div_zero) begin
            result_d = fit_word(in_dec.rem ? a_ext : '1, in_dec.word);
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = in_dec.rem ? '0 : fit_word(a_ext, in_dec.word);
            state_d  = ST_DONE;
          end else begin
            hi_d       = '0;
            lo_d       = in_dec.mul ? b_abs : a_abs;
            opb_d      = in_dec.mul ? a_abs : b_abs;
            quot_neg_d = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            state_d    = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            cnt_d    = '0;
            result_d = fit_word(res_raw, cur_dec.word);
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= MDU_MUL;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opb_q      <= opb_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign mdu_result = result_q;

endmodule
